fifo_rd_arbiter: RTL and testbench

Round-robin read-port arbiter that shares the read side of one FIFO among NUM_REQ consumers. It sits in the FIFO's read-clock domain, between the FIFO read interface and the consumers. It drives the FIFO pop strobe and grants burst-limited access to one requester at a time. Popped words go through a one-entry registered output stage with per-requester valid/ready flow control.

---
 rtl/fifo_rd_arbiter.sv | 113 +++++++++++
 tb/tb_fifo_rd_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter sharing one FWFT FIFO read port among NUM_REQ consumers,
// with burst-limited grants and a one-entry registered output stage.
module fifo_rd_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_REQ-1:0]    i_req,
    input  logic [NUM_REQ-1:0]    i_ready,
    input  logic                  i_rempty,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_rinc,
    output logic [NUM_REQ-1:0]    o_gnt,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] beat_cnt;

    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] next_ptr;
    logic             pick_found;
    logic             req_g;
    logic             ready_g;
    logic             drain_ok;
    logic             pop;
    logic             done;

    // Scan downward so the requester closest above rr_ptr is written last and wins.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (i_req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign req_g    = i_req[gnt_idx];
    assign ready_g  = i_ready[gnt_idx];
    assign drain_ok = !o_valid || ready_g;
    assign next_ptr = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;

    // Pop is masked during reset so a word is never pulled from the FIFO and then dropped.
    assign pop  = (state == XFER) && !i_rst && !i_rempty && req_g
                  && (beat_cnt < BURST_MAX) && drain_ok;
    assign done = (state == XFER) && !pop && drain_ok
                  && ((beat_cnt == BURST_MAX) || !req_g || i_rempty);

    assign o_rinc = pop;
    assign o_busy = (state == XFER);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            gnt_idx  <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            o_gnt    <= '0;
            o_valid  <= 1'b0;
            o_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found && !i_rempty) begin
                        gnt_idx  <= pick_idx;
                        o_gnt    <= NUM_REQ'(1) << pick_idx;
                        beat_cnt <= '0;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (pop) begin
                        o_data   <= i_rdata;
                        o_valid  <= 1'b1;
                        beat_cnt <= beat_cnt + 1'b1;
                    end else if (o_valid && ready_g) begin
                        o_valid <= 1'b0;
                    end
                    if (done) begin
                        state   <= IDLE;
                        o_gnt   <= '0;
                        o_valid <= 1'b0;
                        rr_ptr  <= next_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter: a queue-backed FWFT FIFO model feeds the DUT,
// and a negedge monitor scores delivered words and grants against expected queues.
module tb_fifo_rd_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int MB = 4;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [NR-1:0] i_req;
    logic [NR-1:0] i_ready;
    logic          i_rempty;
    logic [DW-1:0] i_rdata;
    logic          o_rinc;
    logic [NR-1:0] o_gnt;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          o_busy;

    fifo_rd_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_req    (i_req),
        .i_ready  (i_ready),
        .i_rempty (i_rempty),
        .i_rdata  (i_rdata),
        .o_rinc   (o_rinc),
        .o_gnt    (o_gnt),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_busy   (o_busy)
    );

    // ---------------- clock ----------------
    always #5 i_clk = ~i_clk;

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [NR-1:0] gnt_q[$];
    int            len_q[$];
    int            checks = 0;
    int            errors = 0;
    logic          pop_pending = 1'b0;
    logic [NR-1:0] prev_gnt = '0;
    int            pops_in_gnt = 0;
    int            cur_len = 0;
    logic          held = 1'b0;
    logic [DW-1:0] held_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void refresh_fifo();
        i_rempty = (fifo_q.size() == 0);
        i_rdata  = i_rempty ? '0 : fifo_q[0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic load(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + DW'(i));
            exp_q.push_back(base + DW'(i));
        end
        refresh_fifo();
    endtask

    task automatic expect_grant(input logic [NR-1:0] g, input int len);
        gnt_q.push_back(g);
        len_q.push_back(len);
    endtask

    task automatic wait_rinc(input string name);
        int n;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_rinc && n < 50);
        check({name, "_rinc_timeout"}, 32'(o_rinc), 32'(1));
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && o_gnt == '0 && !o_valid) && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        check({name, "_drain_timeout"}, 32'(n >= 300), 32'(0));
    endtask

    // ---------------- FIFO model: pops on the edge after o_rinc was seen ----------------
    always @(posedge i_clk) begin
        #1;
        if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
        refresh_fifo();
    end

    // ---------------- monitor ----------------
    always @(negedge i_clk) begin
        pop_pending = o_rinc;
        if (o_rinc) check("rinc_nonempty", 32'(i_rempty), 32'(0));

        if (held) begin
            check("hold_valid", 32'(o_valid), 32'(1));
            check("hold_data", 32'(o_data), 32'(held_data));
        end
        held      = !i_rst && o_valid && ((i_ready & o_gnt) == '0);
        held_data = o_data;

        if (!i_rst && o_valid && ((i_ready & o_gnt) != '0)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h expected none", o_data);
            end else begin
                check("data", 32'(o_data), 32'(exp_q.pop_front()));
            end
        end

        if (prev_gnt == '0 && o_gnt != '0) begin
            if (gnt_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: got %0h expected none", o_gnt);
                cur_len = -1;
            end else begin
                check("grant", 32'(o_gnt), 32'(gnt_q.pop_front()));
                cur_len = len_q.pop_front();
            end
            pops_in_gnt = 0;
        end else if (prev_gnt != '0 && o_gnt == '0) begin
            check("burst_len", 32'(pops_in_gnt), 32'(cur_len));
        end else if (prev_gnt != '0) begin
            check("grant_stable", 32'(o_gnt), 32'(prev_gnt));
        end
        if (o_rinc) pops_in_gnt++;
        prev_gnt = o_gnt;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        i_rst   = 1'b1;
        i_req   = 4'b0011;
        i_ready = 4'b1111;
        load(8'h10, 3);
        expect_grant(4'b0001, 3);

        // Reset with requests pending and a non-empty FIFO.
        repeat (3) @(negedge i_clk);
        check("rst_gnt", 32'(o_gnt), 32'(0));
        check("rst_valid", 32'(o_valid), 32'(0));
        check("rst_data", 32'(o_data), 32'(0));
        check("rst_busy", 32'(o_busy), 32'(0));
        check("rst_rinc", 32'(o_rinc), 32'(0));
        step();
        i_rst = 1'b0;
        step();
        step();
        check("rst_release_gnt", 32'(o_gnt), 32'(4'b0001));
        drain("t1");
        step();
        i_req = '0;

        // Full bursts: two back-to-back grants to requester 0.
        step();
        i_req = 4'b0001;
        load(8'h20, 8);
        expect_grant(4'b0001, 4);
        expect_grant(4'b0001, 4);
        wait_rinc("t2");
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            check("t2_rinc_run", 32'(o_rinc), 32'(1));
        end
        @(negedge i_clk);
        check("t2_rinc_stop", 32'(o_rinc), 32'(0));
        drain("t2");
        step();
        i_req = '0;

        // Round-robin from a freshly reset pointer.
        step();
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;
        step();
        i_req = 4'b1011;
        load(8'h40, 16);
        expect_grant(4'b0001, 4);
        expect_grant(4'b0010, 4);
        expect_grant(4'b1000, 4);
        expect_grant(4'b0001, 4);
        drain("t3");
        step();
        i_req = '0;

        // Backpressure on requester 2 while others keep ready high.
        step();
        i_req = 4'b0100;
        load(8'h80, 4);
        expect_grant(4'b0100, 4);
        wait_rinc("t4");
        step();
        step();
        i_ready = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            check("t4_bp_rinc", 32'(o_rinc), 32'(0));
            check("t4_bp_valid", 32'(o_valid), 32'(1));
            check("t4_bp_data", 32'(o_data), 32'(8'h81));
            step();
        end
        i_ready = 4'b1111;
        drain("t4");
        step();
        i_req = '0;

        // FIFO runs dry after two words; grant must release early.
        step();
        i_req = 4'b0010;
        load(8'hA0, 2);
        expect_grant(4'b0010, 2);
        drain("t5");
        check("t5_busy", 32'(o_busy), 32'(0));
        step();
        i_req = '0;

        // Reset at beat 2 with a word held in the output stage.
        step();
        i_ready = 4'b0000;
        i_req   = 4'b0001;
        load(8'hC0, 8);
        expect_grant(4'b0001, 2);
        wait_rinc("t6");
        step();
        i_ready = 4'b0001;
        step();
        i_ready = 4'b0000;
        i_rst   = 1'b1;
        @(negedge i_clk);
        check("t6_pre_valid", 32'(o_valid), 32'(1));
        check("t6_pre_data", 32'(o_data), 32'(8'hC1));
        check("t6_pre_rinc", 32'(o_rinc), 32'(0));
        step();
        @(negedge i_clk);
        check("t6_gnt", 32'(o_gnt), 32'(0));
        check("t6_valid", 32'(o_valid), 32'(0));
        check("t6_busy", 32'(o_busy), 32'(0));
        check("t6_rinc", 32'(o_rinc), 32'(0));
        step();
        i_rst = 1'b0;
        i_req = '0;
        fifo_q.delete();
        exp_q.delete();
        refresh_fifo();
        repeat (3) begin
            @(negedge i_clk);
            check("t6_no_rinc", 32'(o_rinc), 32'(0));
        end

        check("grants_left", 32'(gnt_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
